// File: rtl/g0503_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : g0503_sweeper
//  Description : Two-input truth-table sweeper. On an accepted start it drives
//                the vectors {x,y} = 00, 01, 10, 11 to an external device,
//                waits SETTLE cycles after each vector, samples the device
//                response dut_s and compares it against x | ~y. The mismatch
//                count and a pass flag are reported at the end of the sweep.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE           wait cycles between driving a vector and sampling (0..15)
//  Ports
//    clk              rising-edge clock
//    rst_n            asynchronous active-low reset
//    start            sweep request, only honoured while idle
//    x, y             registered stimulus bits to the device under test
//    dut_s            response of the device under test
//    busy             sweep in progress (drive / settle / sample)
//    done             one-cycle completion pulse
//    pass             last completed sweep had no mismatches
//    err_cnt          mismatch count of the current or last sweep (0..4)
//  Optional feature (macro G0503_SWEEP_ERRLOG_EN)
//    first_err_vec    {x,y} of the first mismatching vector of the sweep
//    first_err_valid  first_err_vec holds a captured vector
// ============================================================================
module g0503_sweeper #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       x,
    output logic       y,
    input  logic       dut_s,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt
`ifdef G0503_SWEEP_ERRLOG_EN
    ,
    output logic [1:0] first_err_vec,
    output logic       first_err_valid
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [3:0] C_SETTLE  = SETTLE[3:0];
    localparam logic [2:0] C_ERR_MAX = 3'd7;

    state_t     state_q, state_d;
    logic [1:0] idx_q,   idx_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       x_q,     x_d;
    logic       y_q,     y_d;
    logic       pass_q,  pass_d;
    logic [2:0] err_q,   err_d;
`ifdef G0503_SWEEP_ERRLOG_EN
    logic [1:0] fev_q,   fev_d;
    logic       fval_q,  fval_d;
`endif

    logic       w_expected;
    logic       w_mismatch;

    // Reference function of the device: s = x | ~y, judged on the vector
    // currently held on x/y.
    assign w_expected = x_q | ~y_q;
    assign w_mismatch = (dut_s != w_expected);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        pass_d  = pass_q;
        err_d   = err_q;
`ifdef G0503_SWEEP_ERRLOG_EN
        fev_d   = fev_q;
        fval_d  = fval_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d   = 3'd0;
                    pass_d  = 1'b0;
                    idx_d   = 2'd0;
`ifdef G0503_SWEEP_ERRLOG_EN
                    fev_d   = 2'd0;
                    fval_d  = 1'b0;
`endif
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                x_d     = idx_q[1];
                y_d     = idx_q[0];
                cnt_d   = C_SETTLE;
                state_d = (C_SETTLE != 4'd0) ? S_SETTLE : S_SAMPLE;
            end
            S_SETTLE: begin
                // Leave on the cycle the counter hits zero, giving exactly
                // SETTLE cycles here. The <= 1 also guards a stray zero count.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (w_mismatch) begin
                    if (err_q != C_ERR_MAX) begin
                        err_d = err_q + 3'd1;
                    end
`ifdef G0503_SWEEP_ERRLOG_EN
                    if (!fval_q) begin
                        fev_d  = {x_q, y_q};
                        fval_d = 1'b1;
                    end
`endif
                end
                if (idx_q == 2'd3) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE: begin
                pass_d  = (err_q == 3'd0);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            x_q     <= 1'b0;
            y_q     <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
`ifdef G0503_SWEEP_ERRLOG_EN
            fev_q   <= 2'd0;
            fval_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            pass_q  <= pass_d;
            err_q   <= err_d;
`ifdef G0503_SWEEP_ERRLOG_EN
            fev_q   <= fev_d;
            fval_q  <= fval_d;
`endif
        end
    end

    // busy/done decode straight from the state register so that an
    // asynchronous reset clears them immediately.
    assign busy    = (state_q == S_DRIVE) || (state_q == S_SETTLE) ||
                     (state_q == S_SAMPLE);
    assign done    = (state_q == S_DONE);
    assign x       = x_q;
    assign y       = y_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
`ifdef G0503_SWEEP_ERRLOG_EN
    assign first_err_vec   = fev_q;
    assign first_err_valid = fval_q;
`endif

endmodule
`default_nettype wire
